fire_round_scheduler: RTL and testbench

Sequences the fire hazards of the 3x3 dodge game in rounds: WARN (cells shown as warning), BURN (cells live), COOL (clear). Each round uses a new 9-bit pattern from an internal LFSR. During BURN it compares the player position against the live cells and reports each newly struck cell once per round. The life counter and the top-level game FSM consume these reports. The block sits between the game FSM (which drives `enable` in PLAY) and the display/life logic.

---
 rtl/fire_round_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_fire_round_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fire_round_scheduler.sv
// Round sequencer for the 3x3 dodge game: WARN -> BURN -> COOL with an LFSR pattern per round.
// Define FIRE_SCHED_SPEEDUP_EN to shorten WARN by one tick every 8 completed rounds.
module fire_round_scheduler #(
  parameter int         WARN_TICKS = 4,
  parameter int         BURN_TICKS = 2,
  parameter int         COOL_TICKS = 2,
  parameter int         MIN_WARN   = 1,
  parameter logic [8:0] SEED       = 9'b100100100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enable,
  input  logic [8:0] box,
  output logic [1:0] phase,
  output logic [8:0] fire_warn,
  output logic [8:0] fire_on,
  output logic       hit_valid,
  output logic [3:0] hits,
  output logic [7:0] round
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARN = 2'd1,
    BURN = 2'd2,
    COOL = 2'd3
  } phase_t;

  localparam int MAX_AB    = (WARN_TICKS > BURN_TICKS) ? WARN_TICKS : BURN_TICKS;
  localparam int MAX_TICKS = (MAX_AB > COOL_TICKS) ? MAX_AB : COOL_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);

  phase_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [8:0]    lfsr_q, lfsr_d;
  logic [8:0]    pattern_q, pattern_d;
  logic [8:0]    mask_q, mask_d;
  logic [8:0]    fire_warn_d, fire_on_d;
  logic          hit_valid_d;
  logic [3:0]    hits_d;
  logic [7:0]    round_d;
  logic [8:0]    lfsr_stepped;
  logic [8:0]    new_hits;
  logic          enter_warn;
  logic [4:0]    shrink;

  function automatic logic [8:0] lfsr_step(input logic [8:0] p);
    logic [8:0] n;
    n = {p[7:0], p[0] ^ p[4] ^ p[5] ^ p[8]};
    return (n == 9'd0) ? SEED : n;
  endfunction

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 9; i++) c = c + {3'd0, v[i]};
    return c;
  endfunction

  function automatic logic [CW-1:0] warn_len_for(input logic [4:0] s);
    int len;
    len = WARN_TICKS - int'(s);
    if (len < MIN_WARN) len = MIN_WARN;
    return CW'(len);
  endfunction

`ifdef FIRE_SCHED_SPEEDUP_EN
  assign shrink = round[7:3];
`else
  assign shrink = 5'd0;
`endif

  assign lfsr_stepped = lfsr_step(lfsr_q);
  assign phase        = state_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    lfsr_d      = lfsr_q;
    pattern_d   = pattern_q;
    mask_d      = mask_q;
    round_d     = round;
    hit_valid_d = 1'b0;
    hits_d      = 4'd0;
    new_hits    = 9'd0;
    enter_warn  = 1'b0;

    // Dropping enable behaves exactly like reset and beats any tick or hit.
    if (!enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      len_d     = '0;
      lfsr_d    = SEED;
      pattern_d = 9'd0;
      mask_d    = 9'd0;
      round_d   = 8'd0;
    end else begin
      case (state_q)
        IDLE: enter_warn = 1'b1;
        WARN: begin
          if (tick) begin
            if (cnt_q == len_q - CW'(1)) begin
              state_d = BURN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        BURN: begin
          new_hits    = box & pattern_q & ~mask_q;
          hit_valid_d = |new_hits;
          hits_d      = popcount9(new_hits);
          mask_d      = mask_q | new_hits;
          if (tick) begin
            if (cnt_q == CW'(BURN_TICKS - 1)) begin
              state_d = COOL;
              cnt_d   = '0;
              round_d = (round == 8'hFF) ? round : round + 8'd1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        COOL: begin
          if (tick) begin
            if (cnt_q == CW'(COOL_TICKS - 1)) enter_warn = 1'b1;
            else                              cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Every new round starts with a fresh pattern, a clear strike mask and its own WARN length.
    if (enter_warn) begin
      state_d   = WARN;
      cnt_d     = '0;
      lfsr_d    = lfsr_stepped;
      pattern_d = lfsr_stepped;
      mask_d    = 9'd0;
      len_d     = warn_len_for(shrink);
    end

    fire_warn_d = (state_d == WARN) ? pattern_d : 9'd0;
    fire_on_d   = (state_d == BURN) ? pattern_d : 9'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      lfsr_q    <= SEED;
      pattern_q <= 9'd0;
      mask_q    <= 9'd0;
      fire_warn <= 9'd0;
      fire_on   <= 9'd0;
      hit_valid <= 1'b0;
      hits      <= 4'd0;
      round     <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      lfsr_q    <= lfsr_d;
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      fire_warn <= fire_warn_d;
      fire_on   <= fire_on_d;
      hit_valid <= hit_valid_d;
      hits      <= hits_d;
      round     <= round_d;
    end
  end

endmodule

// File: tb/tb_fire_round_scheduler.sv
// Self-checking bench for fire_round_scheduler: tick-count round model plus directed scenarios.
// Honours FIRE_SCHED_SPEEDUP_EN in the same way as the design.
module tb_fire_round_scheduler;

  localparam int         W      = 4;
  localparam int         B      = 2;
  localparam int         C      = 2;
  localparam int         MINW   = 1;
  localparam logic [8:0] SEED_V = 9'h124;

  logic       clk = 1'b0;
  logic       rst, tick, enable;
  logic [8:0] box;
  logic [1:0] phase;
  logic [8:0] fire_warn, fire_on;
  logic       hit_valid;
  logic [3:0] hits;
  logic [7:0] round;

  int n_cmp = 0;
  int n_fail = 0;
  bit check_en = 1'b0;
  int cyc = 0;
  int pulses = 0;
  int hit_sum = 0;

  fire_round_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .box(box),
    .phase(phase), .fire_warn(fire_warn), .fire_on(fire_on),
    .hit_valid(hit_valid), .hits(hits), .round(round)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // The model counts ticks since WARN entry and derives everything from round lengths.
  function automatic logic [8:0] lfsr_next(input logic [8:0] p);
    logic [8:0] n;
    n = {p[7:0], p[0] ^ p[4] ^ p[5] ^ p[8]};
    return (n == 9'd0) ? SEED_V : n;
  endfunction

  function automatic logic [8:0] pattern_of(input int r);
    logic [8:0] p;
    p = SEED_V;
    for (int i = 0; i <= r; i++) p = lfsr_next(p);
    return p;
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int warn_len(input int r);
`ifdef FIRE_SCHED_SPEEDUP_EN
    int l;
    l = W - sat255(r) / 8;
    return (l < MINW) ? MINW : l;
`else
    return W + 0 * r;
`endif
  endfunction

  task automatic view(input int tt, output logic [1:0] ph, output int r,
                      output logic [8:0] pat, output int rnd);
    int rem;
    rem = tt;
    r = 0;
    while (rem >= warn_len(r) + B + C) begin
      rem -= warn_len(r) + B + C;
      r++;
    end
    pat = pattern_of(r);
    if (rem < warn_len(r)) begin
      ph = 2'd1; rnd = sat255(r);
    end else if (rem < warn_len(r) + B) begin
      ph = 2'd2; rnd = sat255(r);
    end else begin
      ph = 2'd3; rnd = sat255(r + 1);
    end
  endtask

  int         t = 0;
  bit         active = 1'b0;
  logic [8:0] struck = 9'd0;
  logic [8:0] fresh;
  int         struck_r = 0;
  logic [1:0] m_ph;
  int         m_r, m_rnd;
  logic [8:0] m_pat;
  logic [1:0] exp_phase = 2'd0;
  logic [8:0] exp_warn = 9'd0, exp_on = 9'd0;
  logic       exp_hv = 1'b0;
  logic [3:0] exp_hits = 4'd0;
  logic [7:0] exp_round = 8'd0;

  initial begin
    forever begin
      @(posedge clk);
      exp_hv = 1'b0;
      exp_hits = 4'd0;
      if (rst || !enable) begin
        active = 1'b0;
        t = 0;
      end else if (!active) begin
        active = 1'b1;
        t = 0;
        struck = 9'd0;
        struck_r = 0;
      end else begin
        view(t, m_ph, m_r, m_pat, m_rnd);
        if (m_ph == 2'd2) begin
          if (m_r != struck_r) begin
            struck = 9'd0;
            struck_r = m_r;
          end
          fresh = box & m_pat & ~struck;
          struck = struck | fresh;
          exp_hv = |fresh;
          exp_hits = 4'($countones(fresh));
        end
        if (tick) t++;
      end
      if (active) begin
        view(t, m_ph, m_r, m_pat, m_rnd);
        exp_phase = m_ph;
        exp_warn  = (m_ph == 2'd1) ? m_pat : 9'd0;
        exp_on    = (m_ph == 2'd2) ? m_pat : 9'd0;
        exp_round = 8'(m_rnd);
      end else begin
        exp_phase = 2'd0;
        exp_warn  = 9'd0;
        exp_on    = 9'd0;
        exp_round = 8'd0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        checkOutput("cmp_phase", 16'(phase), 16'(exp_phase));
        checkOutput("cmp_fire_warn", 16'(fire_warn), 16'(exp_warn));
        checkOutput("cmp_fire_on", 16'(fire_on), 16'(exp_on));
        checkOutput("cmp_hit_valid", 16'(hit_valid), 16'(exp_hv));
        checkOutput("cmp_hits", 16'(hits), 16'(exp_hits));
        checkOutput("cmp_round", 16'(round), 16'(exp_round));
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic e, input logic [8:0] b, input logic tk);
    rst = r;
    enable = e;
    box = b;
    tick = tk;
    cyc++;
    @(negedge clk);
    if (hit_valid === 1'b1) begin
      pulses++;
      hit_sum += int'(hits);
    end
  endtask

  task automatic runUntilPhase(input logic [1:0] target, input logic [8:0] b, output int ticks);
    int   n;
    logic tk;
    n = 0;
    ticks = 0;
    while (phase !== target && n < 300) begin
      tk = ((cyc % 4) == 0);
      if (tk) ticks++;
      applyStimulus(1'b0, 1'b1, b, tk);
      n++;
    end
    if (phase !== target) checkOutput("timeout_phase", 16'(phase), 16'(target));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  int tw, tb_, tc, e;
  logic [8:0] bx;

  initial begin
    rst = 1'b1; enable = 1'b0; tick = 1'b0; box = 9'd0;
    @(negedge clk);
    check_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 9'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 9'd0, 1'b0);
    checkOutput("reset_phase", 16'(phase), 16'd0);
    checkOutput("reset_round", 16'(round), 16'd0);
    checkOutput("reset_fire_on", 16'(fire_on), 16'd0);
    checkOutput("reset_hit_valid", 16'(hit_valid), 16'd0);

    // Enable with a tick on the entry edge; that tick must not count.
    applyStimulus(1'b0, 1'b1, 9'h008, 1'b1);
    checkOutput("first_warn_phase", 16'(phase), 16'd1);
    checkOutput("first_warn_pattern", 16'(fire_warn), 16'h048);

    runUntilPhase(2'd2, 9'h008, tw);
    checkOutput("warn_ticks_r0", 16'(tw), 16'd4);
    checkOutput("burn_pattern_r0", 16'(fire_on), 16'h048);
    pulses = 0; hit_sum = 0;
    applyStimulus(1'b0, 1'b1, 9'h008, 1'b0);
    checkOutput("hit_one_after_entry", 16'(hit_valid), 16'd1);
    checkOutput("hits_one_after_entry", 16'(hits), 16'd1);
    runUntilPhase(2'd3, 9'h008, tb_);
    checkOutput("burn_ticks_r0", 16'(tb_), 16'd2);
    checkOutput("round_after_burn", 16'(round), 16'd1);
    runUntilPhase(2'd1, 9'h008, tc);
    checkOutput("cool_ticks_r0", 16'(tc), 16'd2);
    checkOutput("single_cell_pulses", 16'(pulses), 16'd1);
    checkOutput("single_cell_hits", 16'(hit_sum), 16'd1);

    // Round 1 pattern; drop enable on the first BURN cycle with overlap present.
    runUntilPhase(2'd2, 9'h010, tw);
    checkOutput("burn_pattern_r1", 16'(fire_on), 16'h090);
    applyStimulus(1'b0, 1'b0, 9'h010, 1'b1);
    checkOutput("drop_phase", 16'(phase), 16'd0);
    checkOutput("drop_fire_on", 16'(fire_on), 16'd0);
    checkOutput("drop_round", 16'(round), 16'd0);
    checkOutput("drop_hit_valid", 16'(hit_valid), 16'd0);
    applyStimulus(1'b0, 1'b1, 9'd0, 1'b0);
    checkOutput("reenable_pattern", 16'(fire_warn), 16'h048);

    pulses = 0; hit_sum = 0;
    runUntilPhase(2'd2, 9'h048, tw);
    runUntilPhase(2'd3, 9'h048, tb_);
    runUntilPhase(2'd1, 9'h048, tc);
    checkOutput("two_cell_pulses", 16'(pulses), 16'd1);
    checkOutput("two_cell_hits", 16'(hit_sum), 16'd2);

    applyStimulus(1'b0, 1'b0, 9'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 9'd0, 1'b0);
    pulses = 0; hit_sum = 0;
    runUntilPhase(2'd2, 9'd0, tw);
    applyStimulus(1'b0, 1'b1, 9'h040, ((cyc % 4) == 0));
    applyStimulus(1'b0, 1'b1, 9'h008, ((cyc % 4) == 0));
    applyStimulus(1'b0, 1'b1, 9'h040, ((cyc % 4) == 0));
    checkOutput("repeat_cell_no_pulse", 16'(hit_valid), 16'd0);
    runUntilPhase(2'd3, 9'd0, tb_);
    runUntilPhase(2'd1, 9'd0, tc);
    checkOutput("moving_box_pulses", 16'(pulses), 16'd2);
    checkOutput("moving_box_hits", 16'(hit_sum), 16'd2);

    // Reset during COOL with tick high on the same edge.
    runUntilPhase(2'd3, 9'd0, tb_);
    applyStimulus(1'b1, 1'b1, 9'd0, 1'b1);
    checkOutput("cool_rst_phase", 16'(phase), 16'd0);
    checkOutput("cool_rst_round", 16'(round), 16'd0);
    checkOutput("cool_rst_fire_warn", 16'(fire_warn), 16'd0);
    checkOutput("cool_rst_fire_on", 16'(fire_on), 16'd0);
    checkOutput("cool_rst_hit_valid", 16'(hit_valid), 16'd0);

    // Long run to see how WARN length evolves with the round count.
    applyStimulus(1'b0, 1'b1, 9'd0, 1'b0);
    for (int k = 0; k <= 30; k++) begin
      bx = ((k % 3) == 0) ? 9'h1FF : 9'(9'h001 << (k % 9));
      runUntilPhase(2'd2, bx, tw);
      checkOutput("round_at_burn", 16'(round), 16'(k));
`ifdef FIRE_SCHED_SPEEDUP_EN
      case (k)
        0, 7:   e = 4;
        8:      e = 3;
        23:     e = 2;
        24, 30: e = 1;
        default: e = -1;
      endcase
`else
      case (k)
        0, 8, 24, 30: e = 4;
        default:      e = -1;
      endcase
`endif
      if (e >= 0) checkOutput("warn_len_long_run", 16'(tw), 16'(e));
      runUntilPhase(2'd3, bx, tb_);
      runUntilPhase(2'd1, bx, tc);
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
